// File: rtl/rename_pkg.sv
// Shared constants, tag types and FSM encoding for the register rename unit.
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int ARCH_W   = 5;
  localparam int PHYS_W   = 6;
  localparam int CNT_W    = 7;

  typedef logic [ARCH_W-1:0] arch_t;
  typedef logic [PHYS_W-1:0] phys_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RECOVER
  } state_e;

  // Out of reset arch i holds tag i, so only the upper half of the tag space is free.
  localparam logic [NUM_PHYS-1:0] FREE_RESET = {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

endpackage

// File: rtl/free_list_picker.sv
// Lowest-set-bit picker over the free bitmap; the tag being freed this cycle is masked out.
module free_list_picker
  import rename_pkg::*;
(
  input  logic [NUM_PHYS-1:0] free_i,
  input  logic                mask_en_i,
  input  logic [PHYS_W-1:0]   mask_tag_i,
  output logic [PHYS_W-1:0]   tag_o,
  output logic                any_o
);

  logic [NUM_PHYS-1:0] avail;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    avail = free_i;
    if (mask_en_i) avail[mask_tag_i] = 1'b0;
    tag_o = '0;
    any_o = 1'b0;
    for (int i = NUM_PHYS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        tag_o = phys_t'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_rename_unit.sv
// Rename stage: speculative/committed RATs, free-list allocation and the ROB request handshake.
// Optional build macro RENAME_X0_ZERO_EN pins arch register 0 to tag 0 and never renames it.
module register_rename_unit
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [ARCH_W-1:0] dec_rs1,
  input  logic [ARCH_W-1:0] dec_rs2,
  input  logic [ARCH_W-1:0] dec_rd,
  input  logic              dec_rd_we,
  output logic              dec_ready,
  output logic              ren_valid,
  output logic [PHYS_W-1:0] ren_ps1,
  output logic [PHYS_W-1:0] ren_ps2,
  output logic [PHYS_W-1:0] ren_pd,
  output logic              ren_has_pd,
  output logic              rob_alloc_valid,
  output logic [ARCH_W-1:0] rob_alloc_dest_arch,
  output logic [PHYS_W-1:0] rob_alloc_dest_phys,
  input  logic              rob_alloc_accepted,
  input  logic              commit_valid,
  input  logic [ARCH_W-1:0] commit_dest_arch,
  input  logic [PHYS_W-1:0] commit_dest_phys,
  input  logic              recover
);

  state_e              state_q;
  phys_t               spec_rat_q [NUM_ARCH];
  phys_t               comm_rat_q [NUM_ARCH];
  phys_t               comm_rat_d [NUM_ARCH];
  logic [NUM_PHYS-1:0] free_q, free_d, mapped, recov_free;
  logic [CNT_W-1:0]    free_count_q, free_count_d, recov_count;
  arch_t               rd_q;
  phys_t               pd_q, ps1_q, ps2_q;
  logic                ren_valid_q, ren_has_pd_q, rob_alloc_valid_q;
  phys_t               ren_ps1_q, ren_ps2_q, ren_pd_q, rob_dest_phys_q;
  arch_t               rob_dest_arch_q;

  logic  eff_we, commit_en, commit_frees, capture, alloc_fire, pick_any;
  phys_t rs1_tag, rs2_tag, old_phys, pick_tag;

`ifdef RENAME_X0_ZERO_EN
  assign eff_we    = dec_rd_we && (dec_rd != '0);
  assign rs1_tag   = (dec_rs1 == '0) ? '0 : spec_rat_q[dec_rs1];
  assign rs2_tag   = (dec_rs2 == '0) ? '0 : spec_rat_q[dec_rs2];
  assign commit_en = commit_valid && (commit_dest_arch != '0);
`else
  assign eff_we    = dec_rd_we;
  assign rs1_tag   = spec_rat_q[dec_rs1];
  assign rs2_tag   = spec_rat_q[dec_rs2];
  assign commit_en = commit_valid;
`endif

  assign old_phys     = comm_rat_q[commit_dest_arch];
  assign commit_frees = commit_en && (old_phys != commit_dest_phys);
  assign dec_ready    = !reset && (state_q == ST_IDLE) &&
                        (((free_count_q != '0) && pick_any) || !eff_we);
  assign capture      = dec_valid && dec_ready;
  assign alloc_fire   = (state_q == ST_WAIT) && rob_alloc_accepted;

  free_list_picker u_picker (
    .free_i     (free_q),
    .mask_en_i  (commit_frees),
    .mask_tag_i (old_phys),
    .tag_o      (pick_tag),
    .any_o      (pick_any)
  );

  // Committed view including this cycle's commit; also the source for recovery.
  always_comb begin
    comm_rat_d = comm_rat_q;
    if (commit_en) comm_rat_d[commit_dest_arch] = commit_dest_phys;
    mapped = '0;
    for (int a = 0; a < NUM_ARCH; a++) mapped[comm_rat_d[a]] = 1'b1;
    recov_free  = ~mapped;
    recov_count = '0;
    for (int p = 0; p < NUM_PHYS; p++) recov_count = recov_count + CNT_W'(recov_free[p]);
  end

  always_comb begin
    free_d       = free_q;
    free_count_d = free_count_q;
    if (commit_frees && !free_q[old_phys]) begin
      free_d[old_phys] = 1'b1;
      free_count_d     = free_count_d + CNT_W'(1);
    end
    if (alloc_fire) begin
      free_d[pd_q] = 1'b0;
      free_count_d = free_count_d - CNT_W'(1);
    end
  end

  // NOTE: both RATs are reset because the identity mapping is architectural state, not a don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_ARCH; i++) begin
        spec_rat_q[i] <= phys_t'(i);
        comm_rat_q[i] <= phys_t'(i);
      end
      free_q            <= FREE_RESET;
      free_count_q      <= CNT_W'(NUM_ARCH);
      rd_q              <= '0;
      pd_q              <= '0;
      ps1_q             <= '0;
      ps2_q             <= '0;
      ren_valid_q       <= 1'b0;
      ren_has_pd_q      <= 1'b0;
      ren_ps1_q         <= '0;
      ren_ps2_q         <= '0;
      ren_pd_q          <= '0;
      rob_alloc_valid_q <= 1'b0;
      rob_dest_arch_q   <= '0;
      rob_dest_phys_q   <= '0;
    end else begin
      comm_rat_q        <= comm_rat_d;
      ren_valid_q       <= 1'b0;
      rob_alloc_valid_q <= 1'b0;
      if (recover) begin
        spec_rat_q   <= comm_rat_d;
        free_q       <= recov_free;
        free_count_q <= recov_count;
        state_q      <= ST_RECOVER;
      end else begin
        free_q       <= free_d;
        free_count_q <= free_count_d;
        case (state_q)
          ST_IDLE: begin
            if (capture && eff_we) begin
              rd_q              <= dec_rd;
              pd_q              <= pick_tag;
              ps1_q             <= rs1_tag;
              ps2_q             <= rs2_tag;
              rob_alloc_valid_q <= 1'b1;
              rob_dest_arch_q   <= dec_rd;
              rob_dest_phys_q   <= pick_tag;
              state_q           <= ST_REQ;
            end else if (capture) begin
              ren_valid_q  <= 1'b1;
              ren_has_pd_q <= 1'b0;
              ren_ps1_q    <= rs1_tag;
              ren_ps2_q    <= rs2_tag;
              ren_pd_q     <= '0;
            end
          end
          ST_REQ: state_q <= ST_WAIT;
          ST_WAIT: begin
            if (rob_alloc_accepted) begin
              spec_rat_q[rd_q] <= pd_q;
              ren_valid_q      <= 1'b1;
              ren_has_pd_q     <= 1'b1;
              ren_ps1_q        <= ps1_q;
              ren_ps2_q        <= ps2_q;
              ren_pd_q         <= pd_q;
              state_q          <= ST_IDLE;
            end else begin
              rob_alloc_valid_q <= 1'b1;
              state_q           <= ST_REQ;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ren_valid           = ren_valid_q;
  assign ren_ps1             = ren_ps1_q;
  assign ren_ps2             = ren_ps2_q;
  assign ren_pd              = ren_pd_q;
  assign ren_has_pd          = ren_has_pd_q;
  assign rob_alloc_valid     = rob_alloc_valid_q;
  assign rob_alloc_dest_arch = rob_dest_arch_q;
  assign rob_alloc_dest_phys = rob_dest_phys_q;

endmodule

// File: tb/tb_register_rename_unit.sv
// Directed bench for register_rename_unit; the bench acts as decoder, ROB and commit source.
module tb_register_rename_unit;

  logic       clk;
  logic       reset;
  logic       dec_valid, dec_rd_we, dec_ready;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       ren_valid, ren_has_pd;
  logic [5:0] ren_ps1, ren_ps2, ren_pd;
  logic       rob_alloc_valid, rob_alloc_accepted;
  logic [4:0] rob_alloc_dest_arch;
  logic [5:0] rob_alloc_dest_phys;
  logic       commit_valid, recover;
  logic [4:0] commit_dest_arch;
  logic [5:0] commit_dest_phys;

  int n_vec  = 0;
  int n_miss = 0;

  register_rename_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .dec_valid           (dec_valid),
    .dec_rs1             (dec_rs1),
    .dec_rs2             (dec_rs2),
    .dec_rd              (dec_rd),
    .dec_rd_we           (dec_rd_we),
    .dec_ready           (dec_ready),
    .ren_valid           (ren_valid),
    .ren_ps1             (ren_ps1),
    .ren_ps2             (ren_ps2),
    .ren_pd              (ren_pd),
    .ren_has_pd          (ren_has_pd),
    .rob_alloc_valid     (rob_alloc_valid),
    .rob_alloc_dest_arch (rob_alloc_dest_arch),
    .rob_alloc_dest_phys (rob_alloc_dest_phys),
    .rob_alloc_accepted  (rob_alloc_accepted),
    .commit_valid        (commit_valid),
    .commit_dest_arch    (commit_dest_arch),
    .commit_dest_phys    (commit_dest_phys),
    .recover             (recover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dec_valid = 1'b0; dec_rd_we = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    rob_alloc_accepted = 1'b0; commit_valid = 1'b0; commit_dest_arch = '0;
    commit_dest_phys = '0; recover = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", dec_ready, 0);
    check("rst_ren_valid", ren_valid, 0);
    check("rst_alloc_valid", rob_alloc_valid, 0);
    check("rst_ren_pd", ren_pd, 0);
    reset = 1'b0;
    @(negedge clk);
    dec_rd_we = 1'b1;
    #1;
    check("post_rst_ready", dec_ready, 1);
    dec_rd_we = 1'b0;
  endtask

  task automatic do_commit(input logic [4:0] a, input logic [5:0] p);
    commit_valid = 1'b1; commit_dest_arch = a; commit_dest_phys = p;
    @(negedge clk);
    commit_valid = 1'b0;
  endtask

  // Presents one instruction (optionally alongside a commit), plays the ROB, checks the result.
  task automatic rename(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic we, input int rejects,
                        input logic [5:0] e_ps1, input logic [5:0] e_ps2,
                        input logic [5:0] e_pd, input logic e_has,
                        input logic cmt, input logic [4:0] c_arch, input logic [5:0] c_phys);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_rd_we = we;
    commit_valid = cmt; commit_dest_arch = c_arch; commit_dest_phys = c_phys;
    #1;
    check("cap_ready", dec_ready, 1);
    @(negedge clk);
    dec_valid = 1'b0; dec_rd_we = 1'b0; commit_valid = 1'b0;
    if (e_has) begin
      for (int a = 0; a <= rejects; a++) begin
        check("alloc_valid", rob_alloc_valid, 1);
        check("alloc_phys", rob_alloc_dest_phys, e_pd);
        check("alloc_arch", rob_alloc_dest_arch, rd);
        check("busy_ready", dec_ready, 0);
        @(negedge clk);
        check("wait_alloc_valid", rob_alloc_valid, 0);
        check("wait_ren_valid", ren_valid, 0);
        rob_alloc_accepted = (a == rejects);
        @(negedge clk);
        rob_alloc_accepted = 1'b0;
      end
    end else begin
      check("no_alloc", rob_alloc_valid, 0);
    end
    check("ren_valid", ren_valid, 1);
    check("ren_ps1", ren_ps1, e_ps1);
    check("ren_ps2", ren_ps2, e_ps2);
    check("ren_pd", ren_pd, e_has ? e_pd : 6'd0);
    check("ren_has_pd", ren_has_pd, e_has);
    @(negedge clk);
    check("ren_pulse", ren_valid, 0);
    check("idle_alloc", rob_alloc_valid, 0);
  endtask

  initial begin
    // Basic writing rename, then a read of the renamed source.
    do_reset();
    rename(5, 0, 5, 1, 0, 5, 0, 32, 1, 0, 0, 0);
    rename(5, 6, 6, 0, 0, 32, 6, 0, 0, 0, 0, 0);
    rename(3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);

    // ROB full for three attempts, same tag retried.
    do_reset();
    rename(1, 2, 9, 1, 3, 1, 2, 32, 1, 0, 0, 0);

    // Exhaust the free list, then a commit frees the superseded tag.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      logic [4:0] rd;
      rd = 5'(1 + (i % 31));
      rename(rd, 0, rd, 1, 0, (i == 31) ? 6'd32 : 6'(rd), 0, 6'(32 + i), 1, 0, 0, 0);
    end
    dec_rd_we = 1'b1;
    #1;
    check("empty_ready_we", dec_ready, 0);
    dec_rd_we = 1'b0;
    #1;
    check("empty_ready_nowe", dec_ready, 1);
    do_commit(5, 32);
    dec_rd_we = 1'b1;
    #1;
    check("freed_ready", dec_ready, 1);
    dec_rd_we = 1'b0;
    rename(10, 0, 10, 1, 0, 41, 0, 5, 1, 0, 0, 0);
    dec_rd_we = 1'b1;
    #1;
    check("empty_again", dec_ready, 0);
    dec_rd_we = 1'b0;

    // Commit frees tag 7 in the capture cycle; picker must skip it. Then recover.
    do_reset();
    rename(7, 0, 7, 1, 0, 7, 0, 32, 1, 0, 0, 0);
    rename(7, 0, 7, 1, 0, 32, 0, 33, 1, 1, 7, 32);
    recover = 1'b1;
    @(negedge clk);
    recover = 1'b0;
    dec_rd_we = 1'b1;
    #1;
    check("recover_ready", dec_ready, 0);
    @(negedge clk);
    #1;
    check("after_recover_ready", dec_ready, 1);
    dec_rd_we = 1'b0;
    rename(7, 8, 0, 0, 0, 32, 8, 0, 0, 0, 0, 0);
    rename(1, 0, 8, 1, 0, 1, 0, 7, 1, 0, 0, 0);
    rename(2, 0, 9, 1, 0, 2, 0, 33, 1, 0, 0, 0);

    // Recover drops a pending request; an accept during RECOVER is ignored.
    do_reset();
    dec_valid = 1'b1; dec_rs1 = 3; dec_rs2 = 0; dec_rd = 3; dec_rd_we = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0; dec_rd_we = 1'b0;
    check("drop_alloc_phys", rob_alloc_dest_phys, 32);
    recover = 1'b1;
    @(negedge clk);
    recover = 1'b0;
    rob_alloc_accepted = 1'b1;
    check("drop_rec_alloc", rob_alloc_valid, 0);
    @(negedge clk);
    rob_alloc_accepted = 1'b0;
    check("drop_ren_valid", ren_valid, 0);
    check("drop_no_retry", rob_alloc_valid, 0);
    rename(3, 0, 3, 1, 0, 3, 0, 32, 1, 0, 0, 0);

    // Reset asserted mid-request clears outputs immediately.
    dec_valid = 1'b1; dec_rs1 = 4; dec_rd = 4; dec_rd_we = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0; dec_rd_we = 1'b0;
    check("pre_reset_alloc", rob_alloc_valid, 1);
    reset = 1'b1;
    #1;
    check("async_reset_alloc", rob_alloc_valid, 0);
    check("async_reset_ready", dec_ready, 0);
    do_reset();

`ifdef RENAME_X0_ZERO_EN
    rename(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rename(0, 1, 1, 1, 0, 0, 1, 32, 1, 0, 0, 0);
`else
    rename(0, 1, 0, 1, 0, 0, 1, 32, 1, 0, 0, 0);
    rename(0, 0, 1, 0, 0, 32, 32, 0, 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/register_rename_unit.md
# register_rename_unit

Front-end rename stage: maps architectural registers to physical tags through a speculative RAT, allocates destination tags from a free-list bitmap, and drives the allocation request side of the reorder buffer. It consumes the ROB commit stream to maintain a committed RAT and to free superseded tags. On `recover` it restores the speculative state from the committed state.

## Interface
- `NUM_ARCH`, 32, architectural registers
- `NUM_PHYS`, 64, physical registers
- `ARCH_W`, 5, arch index width
- `PHYS_W`, 6, phys tag width
- `clk` in 1: clock; reset is `reset`, asynchronous, active-high.
- `reset` in 1: asynchronous, active-high reset.
- `dec_valid` in 1: decoded instruction present.
- `dec_rs1` in ARCH_W: source 1 arch index.
- `dec_rs2` in ARCH_W: source 2 arch index.
- `dec_rd` in ARCH_W: destination arch index.
- `dec_rd_we` in 1: instruction writes `dec_rd`.
- `dec_ready` out 1: unit can capture this cycle.
- `ren_valid` out 1: one-cycle pulse, renamed result valid.
- `ren_ps1` out PHYS_W: physical tag for rs1.
- `ren_ps2` out PHYS_W: physical tag for rs2.
- `ren_pd` out PHYS_W: new destination tag.
- `ren_has_pd` out 1: `ren_pd` is meaningful.
- `rob_alloc_valid` out 1: ROB allocation request.
- `rob_alloc_dest_arch` out ARCH_W: arch index sent with the request.
- `rob_alloc_dest_phys` out PHYS_W: phys tag sent with the request.
- `rob_alloc_accepted` in 1: ROB acceptance, registered one cycle after the request.
- `commit_valid` in 1: ROB commit.
- `commit_dest_arch` in ARCH_W: arch index being committed.
- `commit_dest_phys` in PHYS_W: phys tag being committed.
- `recover` in 1: flush speculative state.

## Operation
- Reset state:
  - Spec and committed RAT entry i = i.
  - Free bitmap: bits 32..63 set, 0..31 clear; `free_count` = 32.
  - FSM in IDLE.
  - All outputs 0.
- FSM states are IDLE, REQ, WAIT, RECOVER.
- IDLE:
  - `dec_ready` = 1 when `free_count` != 0 or `dec_rd_we` = 0.
  - On capture, ps1/ps2 are read from the spec RAT and held.
  - `dec_rd_we` = 0: `ren_valid` pulses next cycle with `ren_has_pd` = 0, no ROB entry, stay IDLE.
  - `dec_rd_we` = 1: latch the lowest set free bit as pd (picker), go to REQ.
- REQ:
  - `rob_alloc_valid` = 1 for exactly this cycle, with the latched rd and pd.
  - Go to WAIT.
- WAIT:
  - `rob_alloc_accepted` = 1: spec RAT[rd] <= pd, clear free bit pd, `free_count` -= 1, pulse `ren_valid` with `ren_has_pd` = 1, go to IDLE.
  - Otherwise (ROB full): go back to REQ and retry with the same pd.
- Commit, applied in every state:
  - Committed RAT[arch] <= phys.
  - The previous committed mapping has its free bit set and `free_count` += 1, unless it equals phys.
- ROB `free_phys` outputs are not consumed. Freeing of superseded tags is owned here.
- Same-cycle commit free plus allocation: `free_count` nets to unchanged. The picker must not select the tag being freed that cycle.
- Source read when a spec RAT write lands in the same cycle: returns the old mapping. Rename is serialized, so no bypass is required.

## Timing
- Non-writing instruction: capture at edge T, `ren_valid` at T+1.
- Writing instruction, ROB not full: capture T, `rob_alloc_valid` during T+1, accept sampled T+2, `ren_valid` T+3. `dec_ready` stays low from T until IDLE.
- ROB full: the REQ/WAIT retry loop repeats every 2 cycles.
- `recover`, in any state, takes priority over everything else:
  - Next edge: spec RAT <= committed RAT, with a same-cycle commit forwarded in.
  - Free bitmap <= complement of the mapped set of the committed RAT (after the commit). `free_count` is recomputed.
  - The pending request is dropped; no `ren_valid`, no retry.
  - FSM -> RECOVER for 1 cycle (`dec_ready` = 0), then IDLE.
- An `rob_alloc_accepted` arriving during RECOVER is ignored.
- Reset asserted mid-operation returns every state element to reset values immediately.

## Configuration
- `RENAME_X0_ZERO_EN` defined:
  - Arch 0 is never renamed: an instruction with rd = 0 is treated as `dec_rd_we` = 0.
  - rs = 0 always reads tag 0.
  - Commits to arch 0 are ignored.
- Undefined: x0 is renamed like any other register.

## Structure
- `rename_pkg`: ARCH_W/PHYS_W/NUM_* constants, FSM state enum, reset free-mask constant.
- Sub-module `free_list_picker`:
  - Combinational lowest-set-bit encoder over the free bitmap, with a mask input for the tag freed this cycle.
  - Outputs tag and `any` flag.

## Test plan
- Reset, then rename rd = 5, rs1 = 5, ROB accepts: `rob_alloc_dest_phys` = 32, `ren_pd` = 32, `ren_ps1` = 5. The next rename of rs1 = 5 yields ps1 = 32.
- `dec_rd_we` = 0, rs1 = 3: `ren_valid` 1 cycle after capture, `ren_ps1` = 3, `ren_has_pd` = 0, `rob_alloc_valid` never high.
- Hold `rob_alloc_accepted` = 0 for 3 attempts: `rob_alloc_valid` pulses every 2 cycles with the same tag 32, `dec_ready` stays 0. Accept on the 4th: `ren_valid`.
- Allocate 32 writing instructions with no commits: `free_count` = 0 and `dec_ready` = 0 for a writing dec. Then commit arch 5 -> phys 32: tag 5 freed, `dec_ready` = 1.
- Rename rd = 7 -> 32, commit it, rename rd = 7 -> 33, then `recover`: spec RAT[7] = 32, tag 33 free again. 1 RECOVER cycle, then `dec_ready` = 1.
- With `RENAME_X0_ZERO_EN`: rd = 0 with `dec_rd_we` = 1 -> `ren_has_pd` = 0, no ROB request, `free_count` unchanged.
